axi_burst_master: RTL and testbench

Parametrised AXI-style bus master with independent read and write channel engines, each running multi-beat bursts of configurable data width and length. It sits between testbench or host command logic and a slave/interconnect, turning one-cycle command requests into AR/R and AW/W/B handshake sequences. Write-side beat data is taken from a flat pre-loaded burst vector. Read beats are streamed back one per accepted R transfer.

---
 rtl/axi_burst_master.sv | 204 ++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master.sv
// axi_burst_master: independent AXI read and write burst engines.
// Define AXI_MASTER_LASTCHK_EN to fold RLAST/length mismatches into rd_err.
module axi_burst_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4,
  parameter int RESP_W = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rd_req,
  input  logic [ADDR_W-1:0]              rd_addr,
  input  logic [LEN_W-1:0]               rd_len,
  input  logic [ID_W-1:0]                rd_id,
  output logic                           rd_busy,
  output logic [DATA_W-1:0]              rd_data,
  output logic                           rd_data_valid,
  output logic                           rd_done,
  output logic                           rd_err,
  input  logic                           wr_req,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [LEN_W-1:0]               wr_len,
  input  logic [ID_W-1:0]                wr_id,
  input  logic [(2**LEN_W)*DATA_W-1:0]   wr_data,
  output logic                           wr_busy,
  output logic                           wr_done,
  output logic [RESP_W-1:0]              wr_resp,
  output logic                           ARVALID,
  input  logic                           ARREADY,
  output logic [ADDR_W-1:0]              ARADDR,
  output logic [LEN_W-1:0]               ARLEN,
  output logic [ID_W-1:0]                ARID,
  input  logic                           RVALID,
  output logic                           RREADY,
  input  logic [DATA_W-1:0]              RDATA,
  input  logic [RESP_W-1:0]              RRESP,
  input  logic                           RLAST,
  output logic                           AWVALID,
  input  logic                           AWREADY,
  output logic [ADDR_W-1:0]              AWADDR,
  output logic [LEN_W-1:0]               AWLEN,
  output logic [ID_W-1:0]                AWID,
  output logic                           WVALID,
  input  logic                           WREADY,
  output logic [DATA_W-1:0]              WDATA,
  output logic                           WLAST,
  input  logic                           BVALID,
  output logic                           BREADY,
  input  logic [RESP_W-1:0]              BRESP
);

  localparam int CW = LEN_W + 1;
  localparam int BW = (2**LEN_W) * DATA_W;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_e;

  rstate_e         rstate_q;
  wstate_e         wstate_q;
  logic [CW-1:0]   rcnt_q;
  logic [CW-1:0]   wcnt_q;
  logic [CW-1:0]   wcnt_d;
  logic [BW-1:0]   wbuf_q;
  logic            rbeat_err;

`ifdef AXI_MASTER_LASTCHK_EN
  assign rbeat_err = (RRESP != '0) ||
                     (RLAST != (rcnt_q == {1'b0, ARLEN}));
`else
  assign rbeat_err = (RRESP != '0);
`endif

  assign wcnt_d = wcnt_q + CW'(1);

  // busy stays high through the done cycle and drops one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      rstate_q      <= R_IDLE;
      rcnt_q        <= '0;
      rd_busy       <= 1'b0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
      rd_done       <= 1'b0;
      rd_err        <= 1'b0;
      ARVALID       <= 1'b0;
      ARADDR        <= '0;
      ARLEN         <= '0;
      ARID          <= '0;
      RREADY        <= 1'b0;
    end else begin
      rd_data_valid <= 1'b0;
      rd_done       <= 1'b0;
      unique case (rstate_q)
        R_IDLE: begin
          rd_busy <= 1'b0;
          if (rd_req && !rd_busy) begin
            ARVALID  <= 1'b1;
            ARADDR   <= rd_addr;
            ARLEN    <= rd_len;
            ARID     <= rd_id;
            rd_err   <= 1'b0;
            rd_busy  <= 1'b1;
            rstate_q <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (ARVALID && ARREADY) begin
            ARVALID  <= 1'b0;
            RREADY   <= 1'b1;
            rcnt_q   <= '0;
            rstate_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (RVALID && RREADY) begin
            rd_data       <= RDATA;
            rd_data_valid <= 1'b1;
            rd_err        <= rd_err | rbeat_err;
            rcnt_q        <= rcnt_q + CW'(1);
            if (RLAST) begin
              RREADY   <= 1'b0;
              rd_done  <= 1'b1;
              rstate_q <= R_IDLE;
            end
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  // beats are shifted out of wbuf_q, so WDATA is always its low slice
  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q <= W_IDLE;
      wcnt_q   <= '0;
      wbuf_q   <= '0;
      wr_busy  <= 1'b0;
      wr_done  <= 1'b0;
      wr_resp  <= '0;
      AWVALID  <= 1'b0;
      AWADDR   <= '0;
      AWLEN    <= '0;
      AWID     <= '0;
      WVALID   <= 1'b0;
      WDATA    <= '0;
      WLAST    <= 1'b0;
      BREADY   <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      unique case (wstate_q)
        W_IDLE: begin
          wr_busy <= 1'b0;
          if (wr_req && !wr_busy) begin
            AWVALID  <= 1'b1;
            AWADDR   <= wr_addr;
            AWLEN    <= wr_len;
            AWID     <= wr_id;
            wbuf_q   <= wr_data;
            wr_busy  <= 1'b1;
            wstate_q <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (AWVALID && AWREADY) begin
            AWVALID  <= 1'b0;
            WVALID   <= 1'b1;
            wcnt_q   <= '0;
            WDATA    <= wbuf_q[DATA_W-1:0];
            wbuf_q   <= wbuf_q >> DATA_W;
            WLAST    <= (AWLEN == '0);
            wstate_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (WVALID && WREADY) begin
            if (WLAST) begin
              WVALID   <= 1'b0;
              WLAST    <= 1'b0;
              BREADY   <= 1'b1;
              wstate_q <= W_RESP;
            end else begin
              wcnt_q <= wcnt_d;
              WDATA  <= wbuf_q[DATA_W-1:0];
              wbuf_q <= wbuf_q >> DATA_W;
              WLAST  <= (wcnt_d == {1'b0, AWLEN});
            end
          end
        end
        W_RESP: begin
          if (BVALID && BREADY) begin
            wr_resp  <= BRESP;
            wr_done  <= 1'b1;
            BREADY   <= 1'b0;
            wstate_q <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: randomized scoreboard bench with AXI slave models.
// Expected rd_err adds the RLAST/length rule when AXI_MASTER_LASTCHK_EN is set.
module tb_axi_burst_master;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int IW = 4;
  localparam int LW = 4;
  localparam int RW = 2;
  localparam int NB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_req, rd_busy, rd_data_valid, rd_done, rd_err;
  logic [AW-1:0] rd_addr, wr_addr, ARADDR, AWADDR;
  logic [LW-1:0] rd_len, wr_len, ARLEN, AWLEN;
  logic [IW-1:0] rd_id, wr_id, ARID, AWID;
  logic [DW-1:0] rd_data, RDATA, WDATA;
  logic wr_req, wr_busy, wr_done;
  logic [NB*DW-1:0] wr_data;
  logic [RW-1:0] wr_resp, RRESP, BRESP;
  logic ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;

  axi_burst_master dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_id(rd_id),
    .rd_busy(rd_busy), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .rd_done(rd_done), .rd_err(rd_err),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_id(wr_id),
    .wr_data(wr_data), .wr_busy(wr_busy), .wr_done(wr_done), .wr_resp(wr_resp),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARID(ARID), .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA),
    .RRESP(RRESP), .RLAST(RLAST),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWID(AWID), .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
    .WLAST(WLAST), .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
  );

  always #5 clk = ~clk;

  logic [61:0] all_o;
  assign all_o = {rd_busy, rd_data, rd_data_valid, rd_done, rd_err,
                  wr_busy, wr_done, wr_resp, ARVALID, ARADDR, ARLEN, ARID,
                  RREADY, AWVALID, AWADDR, AWLEN, AWID, WVALID, WDATA,
                  WLAST, BREADY};

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [IW-1:0] id;
  } cmd_t;

  typedef struct {
    int            len;
    logic [NB*DW-1:0] data;
  } wburst_t;

  cmd_t          exp_ar[$];
  cmd_t          exp_aw[$];
  wburst_t       exp_wb[$];
  wburst_t       w_pend[$];
  int            r_len_q[$];
  logic [DW-1:0] exp_rd[$];
  logic          exp_rerr[$];
  logic [RW-1:0] exp_wresp[$];
  int            b_pend = 0;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_beats_seen = 0;
  int w_beats_seen  = 0;

  int            stall_pct  = 0;
  bit            wr_toggle  = 1'b0;
  bit            rand_resp  = 1'b0;
  bit            b_rand     = 1'b0;
  bit            r_fix_en   = 1'b0;
  logic [DW-1:0] r_fix_data = '0;
  int            r_last_at  = -1;
  int            r_err_beat = -1;
  logic [RW-1:0] r_err_val  = '0;

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // read slave: AR acceptance and R beat generation, decided at negedge
  initial begin
    int beat;
    logic err, hold;
    cmd_t c;
    beat = 0; err = 1'b0; hold = 1'b0;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = '0; RLAST = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
        beat = 0; err = 1'b0; hold = 1'b0;
        r_len_q.delete(); exp_ar.delete();
        exp_rd.delete(); exp_rerr.delete();
        continue;
      end
      ARREADY = ($urandom_range(99) >= stall_pct);
      if (ARVALID && ARREADY) begin
        if (exp_ar.size() == 0) check("ar_unexpected", 1'b1, 1'b0);
        else begin
          c = exp_ar.pop_front();
          check("araddr", ARADDR, c.addr);
          check("arlen", ARLEN, c.len);
          check("arid", ARID, c.id);
          r_len_q.push_back(int'(c.len));
        end
      end
      if (!hold) begin
        if (r_len_q.size() > 0 && $urandom_range(99) >= stall_pct) begin
          RVALID = 1'b1;
          RDATA  = r_fix_en ? r_fix_data : DW'($urandom);
          if (beat == r_err_beat) RRESP = r_err_val;
          else if (rand_resp && $urandom_range(7) == 0)
            RRESP = RW'($urandom_range(3, 1));
          else RRESP = '0;
          RLAST = (r_last_at >= 0) ? (beat == r_last_at) : (beat == r_len_q[0]);
        end else begin
          RVALID = 1'b0;
          RLAST  = 1'b0;
        end
      end
      if (RVALID && RREADY) begin
        exp_rd.push_back(RDATA);
        err = err | (RRESP != '0);
`ifdef AXI_MASTER_LASTCHK_EN
        err = err | (RLAST != (beat == r_len_q[0]));
`endif
        beat++;
        if (RLAST) begin
          exp_rerr.push_back(err);
          err = 1'b0;
          beat = 0;
          r_len_q.delete(0);
        end
        hold = 1'b0;
      end else hold = RVALID;
    end
  end

  // write slave: AW acceptance, W beat checking, B response
  initial begin
    int wb;
    logic bhold;
    cmd_t c;
    wburst_t cur;
    wb = 0; bhold = 1'b0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = '0;
        wb = 0; bhold = 1'b0; b_pend = 0;
        w_pend.delete(); exp_aw.delete(); exp_wb.delete();
        exp_wresp.delete();
        continue;
      end
      AWREADY = ($urandom_range(99) >= stall_pct);
      if (AWVALID && AWREADY) begin
        if (exp_aw.size() == 0) check("aw_unexpected", 1'b1, 1'b0);
        else begin
          c = exp_aw.pop_front();
          check("awaddr", AWADDR, c.addr);
          check("awlen", AWLEN, c.len);
          check("awid", AWID, c.id);
          w_pend.push_back(exp_wb.pop_front());
        end
      end
      WREADY = wr_toggle ? !WREADY : ($urandom_range(99) >= stall_pct);
      if (WVALID && WREADY) begin
        if (w_pend.size() == 0) check("w_unexpected", 1'b1, 1'b0);
        else begin
          cur = w_pend[0];
          check("wdata", WDATA, cur.data[wb*DW +: DW]);
          check("wlast", WLAST, wb == cur.len);
          w_beats_seen++;
          if (wb == cur.len) begin
            wb = 0;
            w_pend.delete(0);
            b_pend++;
          end else wb++;
        end
      end
      if (!bhold) begin
        if (b_pend > 0 && $urandom_range(99) >= stall_pct) begin
          BVALID = 1'b1;
          BRESP  = b_rand ? RW'($urandom) : '0;
        end else BVALID = 1'b0;
      end
      if (BVALID && BREADY) begin
        exp_wresp.push_back(BRESP);
        b_pend--;
        bhold = 1'b0;
      end else bhold = BVALID;
    end
  end

  // monitor: pops the scoreboard whenever the DUT presents a result
  initial begin
    logic prev_rdone, prev_wdone;
    prev_rdone = 1'b0; prev_wdone = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_data_valid) begin
        rd_beats_seen++;
        if (exp_rd.size() == 0) check("rd_unexpected", 1'b1, 1'b0);
        else check("rd_data", rd_data, exp_rd.pop_front());
      end
      if (rd_done) begin
        if (exp_rerr.size() == 0) check("rd_done_unexpected", 1'b1, 1'b0);
        else check("rd_err", rd_err, exp_rerr.pop_front());
      end
      if (wr_done) begin
        if (exp_wresp.size() == 0) check("wr_done_unexpected", 1'b1, 1'b0);
        else check("wr_resp", wr_resp, exp_wresp.pop_front());
      end
      if (prev_rdone) check("rd_busy_after_done", rd_busy, 1'b0);
      if (prev_wdone) check("wr_busy_after_done", wr_busy, 1'b0);
      prev_rdone = rd_done;
      prev_wdone = wr_done;
    end
  end

  task automatic issue_rd(input logic [AW-1:0] a, input logic [LW-1:0] l,
                          input logic [IW-1:0] i);
    int t;
    cmd_t c;
    t = 0;
    while (rd_busy && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (rd_busy) begin
      check("rd_idle_timeout", 1'b1, 1'b0);
      return;
    end
    rd_addr = a; rd_len = l; rd_id = i; rd_req = 1'b1;
    c.addr = a; c.len = l; c.id = i;
    exp_ar.push_back(c);
    @(negedge clk);
    rd_req = 1'b0;
    rd_addr = AW'($urandom); rd_len = LW'($urandom); rd_id = IW'($urandom);
  endtask

  task automatic issue_wr(input logic [AW-1:0] a, input logic [LW-1:0] l,
                          input logic [IW-1:0] i, input logic [NB*DW-1:0] d);
    int t;
    cmd_t c;
    wburst_t w;
    t = 0;
    while (wr_busy && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (wr_busy) begin
      check("wr_idle_timeout", 1'b1, 1'b0);
      return;
    end
    wr_addr = a; wr_len = l; wr_id = i; wr_data = d; wr_req = 1'b1;
    c.addr = a; c.len = l; c.id = i;
    w.len = int'(l); w.data = d;
    exp_aw.push_back(c);
    exp_wb.push_back(w);
    @(negedge clk);
    wr_req = 1'b0;
    wr_addr = AW'($urandom); wr_len = LW'($urandom); wr_id = IW'($urandom);
    wr_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((rd_busy || wr_busy || rd_done || wr_done ||
                exp_rd.size() > 0 || exp_rerr.size() > 0 ||
                exp_wresp.size() > 0 || r_len_q.size() > 0 ||
                w_pend.size() > 0 || b_pend > 0) && t < 3000);
    if (t >= 3000) check("idle_timeout", 1'b1, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NB*DW-1:0] d;
    int b0;
    rd_req = 1'b0; rd_addr = '0; rd_len = '0; rd_id = '0;
    wr_req = 1'b0; wr_addr = '0; wr_len = '0; wr_id = '0; wr_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_o, 62'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single-beat read with latency checks
    r_fix_en = 1'b1; r_fix_data = 8'hA5;
    issue_rd(8'h10, 4'd0, 4'd3);
    check("rd_arvalid_cycle1", ARVALID, 1'b1);
    @(negedge clk);
    check("rd_rready_cycle2", RREADY, 1'b1);
    @(negedge clk);
    check("rd_valid_cycle3", rd_data_valid, 1'b1);
    check("rd_done_len0", rd_done, 1'b1);
    wait_idle();
    r_fix_en = 1'b0;

    // four-beat write with WREADY toggling
    wr_toggle = 1'b1;
    d = '0;
    d[31:0] = 32'h44332211;
    issue_wr(8'h40, 4'd3, 4'd5, d);
    check("wr_awvalid_cycle1", AWVALID, 1'b1);
    @(negedge clk);
    check("wr_wvalid_cycle2", WVALID, 1'b1);
    wait_idle();
    check("wr_resp_zero", wr_resp, 2'b00);
    wr_toggle = 1'b0;

    // concurrent read and write
    stall_pct = 20;
    d = {$urandom, $urandom, $urandom, $urandom};
    fork
      issue_rd(8'h22, 4'd2, 4'd1);
      issue_wr(8'h33, 4'd1, 4'd2, d);
    join
    wait_idle();

    // RRESP error on beat 1, then a clean burst clears rd_err
    r_err_beat = 1; r_err_val = 2'd2;
    issue_rd(8'h50, 4'd3, 4'd7);
    wait_idle();
    check("rd_err_sticky", rd_err, 1'b1);
    r_err_beat = -1;
    issue_rd(8'h60, 4'd1, 4'd8);
    check("rd_err_cleared", rd_err, 1'b0);
    wait_idle();

    // early RLAST on beat 1 of a four-beat read
    r_last_at = 1;
    b0 = rd_beats_seen;
    issue_rd(8'h70, 4'd3, 4'd9);
    wait_idle();
    check("early_last_beats", rd_beats_seen - b0, 2);
    r_last_at = -1;

    // reset in the middle of a write data phase
    stall_pct = 0;
    w_beats_seen = 0;
    issue_wr(8'h80, 4'd7, 4'd4, {$urandom, $urandom, $urandom, $urandom});
    b0 = 0;
    while (w_beats_seen < 2 && b0 < 100) begin
      @(negedge clk);
      b0++;
    end
    if (w_beats_seen < 2) check("w_beat_timeout", 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midburst_reset_outputs", all_o, 62'h0);
    check("midburst_reset_busy", wr_busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    issue_wr(8'h90, 4'd2, 4'd6, {$urandom, $urandom, $urandom, $urandom});
    wait_idle();

    // randomized concurrent traffic with backpressure and responses
    stall_pct = 30; rand_resp = 1'b1; b_rand = 1'b1;
    fork
      begin
        for (int k = 0; k < 25; k++)
          issue_rd(AW'($urandom), LW'($urandom), IW'($urandom));
      end
      begin
        for (int k = 0; k < 25; k++)
          issue_wr(AW'($urandom), LW'($urandom), IW'($urandom),
                   {$urandom, $urandom, $urandom, $urandom});
      end
    join
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
